i2c_tx_sequencer: RTL and testbench

//  Packet-level I2C write engine; upstream of i2c_master_top, drives its Wishbone slave port.

---
 rtl/i2c_seq_pkg.sv | 53 +++++
 rtl/wb_single_xfer.sv | 110 +++++++++++
 rtl/i2c_tx_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_i2c_tx_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the I2C packet write sequencer.
// Register map and bit positions follow the OpenCores i2c_master_top register file.
package i2c_seq_pkg;

    // Core register addresses (CR and SR share address 4: write = CR, read = SR)
    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;
    localparam logic [2:0] ADR_SR     = 3'd4;

    // Command register bits
    localparam int unsigned CR_STA  = 7;
    localparam int unsigned CR_STO  = 6;
    localparam int unsigned CR_RD   = 5;
    localparam int unsigned CR_WR   = 4;
    localparam int unsigned CR_ACK  = 3;
    localparam int unsigned CR_IACK = 0;

    // Status register bits
    localparam int unsigned SR_RXACK = 7;
    localparam int unsigned SR_BUSY  = 6;
    localparam int unsigned SR_AL    = 5;
    localparam int unsigned SR_TIP   = 1;
    localparam int unsigned SR_IF    = 0;

    // err_code values
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_ARB     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        StInitPl, StInitPh, StInitCtr, StIdle, StLdTxr, StLdCr, StWaitInt,
        StPoll, StIack, StChk, StStop, StErr, StFlush, StDone
    } state_e;

    typedef enum logic [1:0] {XfIdle, XfBusy, XfGap} xfer_state_e;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    // Write-command byte for one data byte: WR always, STA on first, STO on last
    function automatic logic [7:0] cr_cmd(input logic first, input logic last);
        return (8'h01 << CR_WR) | (first ? (8'h01 << CR_STA) : 8'h00)
                                | (last  ? (8'h01 << CR_STO) : 8'h00);
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone single read or write with an ack timeout.
// Accepts req only when idle; stb/cyc drop on the edge that samples ack (or on timeout),
// followed by one guaranteed idle cycle before the next request is taken.
module wb_single_xfer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned WB_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       timeout,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i
);

    localparam int unsigned CntW = $clog2(WB_TIMEOUT + 1);

    xfer_state_e     st_q, st_d;
    logic            stb_q, stb_d, we_q, we_d, ack_q, ack_d, to_q, to_d;
    logic [2:0]      adr_q, adr_d;
    logic [7:0]      dat_q, dat_d, rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Transfer state and bus registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= XfIdle;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
            adr_q   <= 3'd0;
            dat_q   <= 8'd0;
            rdata_q <= 8'd0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            to_q    <= to_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: launch, wait for ack or timeout, then one gap cycle
    always_comb begin
        st_d    = st_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        to_d    = 1'b0;
        case (st_q)
            XfIdle: begin
                if (req) begin
                    stb_d = 1'b1;
                    we_d  = we;
                    adr_d = addr;
                    dat_d = wdata;
                    cnt_d = '0;
                    st_d  = XfBusy;
                end
            end
            XfBusy: begin
                if (wb_ack_i) begin
                    stb_d   = 1'b0;
                    rdata_d = wb_dat_i;
                    ack_d   = 1'b1;
                    st_d    = XfGap;
                end else if (cnt_q == CntW'(WB_TIMEOUT - 1)) begin
                    stb_d = 1'b0;
                    to_d  = 1'b1;
                    st_d  = XfGap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            XfGap:   st_d = XfIdle;
            default: st_d = XfIdle;
        endcase
    end

    assign ack      = ack_q;
    assign timeout  = to_q;
    assign rdata    = rdata_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = stb_q;

endmodule

// File: rtl/i2c_tx_sequencer.sv
// Packet-level I2C write engine driving the Wishbone port of i2c_master_top.
// Bytes are queued in a small FIFO; each goes out as TXR write, CR write, then SR check.
// Optional I2C_INT_WAIT_EN: enable core interrupt, wait for wb_inta_i, read SR once and IACK.
module i2c_tx_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE   = 16'h008F,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WB_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_first,
    input  logic       s_last,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i,
    input  logic       wb_inta_i
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef I2C_INT_WAIT_EN
    localparam logic [7:0] CtrInit = 8'hC0;
`else
    localparam logic [7:0] CtrInit = 8'h80;
`endif

    state_e      state_q, state_d;
    fifo_entry_t cur_q, cur_d, head;
    fifo_entry_t mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic [1:0]  err_code_q, err_code_d;
    logic        pkt_open_q, pkt_open_d, init_done_q, init_done_d;
    logic        push, pop, empty, full;
    logic        x_req, x_we, x_ack, x_timeout;
    logic [2:0]  x_addr;
    logic [7:0]  x_wdata, sr;
    logic        unused_inta, unused_sr;

    assign unused_inta = wb_inta_i;
    assign unused_sr   = ^sr;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head    = mem_q[rd_q[AW-1:0]];
    // A full FIFO still accepts a byte in the cycle the sequencer pops one
    assign s_ready = init_done_q && (!full || pop);
    assign push    = s_valid && s_ready;

    // FIFO storage (no reset needed, validity is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {s_first, s_last, s_data};
    end

    // FIFO pointers and sequencer state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            state_q     <= StInitPl;
            cur_q       <= '0;
            err_code_q  <= ERR_NONE;
            pkt_open_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + (AW + 1)'(1);
            if (pop)  rd_q <= rd_q + (AW + 1)'(1);
            state_q     <= state_d;
            cur_q       <= cur_d;
            err_code_q  <= err_code_d;
            pkt_open_q  <= pkt_open_d;
            init_done_q <= init_done_d;
        end
    end

    // Sequencer next-state and transfer requests
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        err_code_d  = err_code_q;
        pkt_open_d  = pkt_open_q;
        init_done_d = init_done_q;
        pop         = 1'b0;
        x_req       = 1'b0;
        x_we        = 1'b1;
        x_addr      = ADR_CR;
        x_wdata     = 8'h00;
        case (state_q)
            StInitPl: begin
                x_req   = 1'b1;
                x_addr  = ADR_PRERLO;
                x_wdata = PRESCALE[7:0];
                if (x_ack) state_d = StInitPh;
            end
            StInitPh: begin
                x_req   = 1'b1;
                x_addr  = ADR_PRERHI;
                x_wdata = PRESCALE[15:8];
                if (x_ack) state_d = StInitCtr;
            end
            StInitCtr: begin
                x_req   = 1'b1;
                x_addr  = ADR_CTR;
                x_wdata = CtrInit;
                if (x_ack) begin
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StIdle: begin
                if (!empty) begin
                    pop = 1'b1;
                    // Orphan bytes (no open packet, not a first) are silently dropped
                    if (head.first || pkt_open_q) begin
                        cur_d   = head;
                        state_d = StLdTxr;
                        if (head.first) begin
                            pkt_open_d = 1'b1;
                            err_code_d = ERR_NONE;
                        end
                    end
                end
            end
            StLdTxr: begin
                x_req   = 1'b1;
                x_addr  = ADR_TXR;
                x_wdata = cur_q.data;
                if (x_ack) state_d = StLdCr;
            end
            StLdCr: begin
                x_req   = 1'b1;
                x_wdata = cr_cmd(cur_q.first, cur_q.last);
`ifdef I2C_INT_WAIT_EN
                if (x_ack) state_d = StWaitInt;
            end
            StWaitInt: begin
                if (wb_inta_i) state_d = StPoll;
`else
                if (x_ack) state_d = StPoll;
`endif
            end
            StPoll: begin
                x_req  = 1'b1;
                x_we   = 1'b0;
                x_addr = ADR_SR;
`ifdef I2C_INT_WAIT_EN
                if (x_ack) state_d = StIack;
            end
            StIack: begin
                // STOP rides along with the IACK when the byte was NACKed
                x_req   = 1'b1;
                x_wdata = (8'h01 << CR_IACK)
                        | ((sr[SR_RXACK] && !sr[SR_AL]) ? (8'h01 << CR_STO) : 8'h00);
                if (x_ack) state_d = StChk;
            end
            StChk: begin
                if (sr[SR_AL]) begin
                    err_code_d = ERR_ARB;
                    state_d    = StErr;
                end else if (sr[SR_RXACK]) begin
                    err_code_d = ERR_NACK;
                    state_d    = StErr;
                end else begin
                    state_d = cur_q.last ? StDone : StIdle;
                end
            end
`else
                if (x_ack) state_d = StChk;
            end
            StChk: begin
                if (sr[SR_TIP]) begin
                    state_d = StPoll;
                end else if (sr[SR_AL]) begin
                    err_code_d = ERR_ARB;
                    state_d    = StErr;
                end else if (sr[SR_RXACK]) begin
                    err_code_d = ERR_NACK;
                    state_d    = StStop;
                end else begin
                    state_d = cur_q.last ? StDone : StIdle;
                end
            end
`endif
            StStop: begin
                x_req   = 1'b1;
                x_wdata = 8'h01 << CR_STO;
                if (x_ack) state_d = StErr;
            end
            StErr: begin
                pkt_open_d = 1'b0;
                if (err_code_q == ERR_TIMEOUT) state_d = StInitPl;
                else if (cur_q.last)           state_d = StIdle;
                else                           state_d = StFlush;
            end
            StFlush: begin
                // Discard the rest of the aborted packet, waiting for its last byte
                if (!empty) begin
                    pop = 1'b1;
                    if (head.last) state_d = StIdle;
                end
            end
            StDone: begin
                pkt_open_d = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StInitPl;
        endcase
        // A dead bus aborts whatever is in flight and re-initialises the core
        if (x_timeout) begin
            err_code_d = ERR_TIMEOUT;
            state_d    = StErr;
        end
    end

    assign busy     = (state_q != StIdle) || (!empty && (pkt_open_q || head.first));
    assign done     = (state_q == StDone);
    assign err      = (state_q == StErr);
    assign err_code = err_code_q;

    wb_single_xfer #(
        .WB_TIMEOUT (WB_TIMEOUT)
    ) u_xfer (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (x_req),
        .addr     (x_addr),
        .wdata    (x_wdata),
        .we       (x_we),
        .ack      (x_ack),
        .rdata    (sr),
        .timeout  (x_timeout),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_ack_i (wb_ack_i)
    );

endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// Self-checking bench for i2c_tx_sequencer with a behavioural i2c core register model.
module tb_i2c_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0, s_first = 1'b0, s_last = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, busy, done, err;
    logic [1:0] err_code;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_inta_i;

    always #5 clk = ~clk;

`ifdef I2C_INT_WAIT_EN
    localparam logic [7:0] CtrExp = 8'hC0;
`else
    localparam logic [7:0] CtrExp = 8'h80;
`endif

    // Behavioural core model
    logic       ack_m = 1'b0, stub = 1'b0;
    logic [7:0] rd_m = 8'h00;
    logic       if_m = 1'b0, ien_m = 1'b0, rxack_m = 1'b0, al_m = 1'b0;
    int         lat = 1, lat_cnt = 0, timer = 0, byte_idx = 0, nack_abs = -1, al_abs = -1;
    int         tip_reads = 0, stb_run = 0, last_run = 0, done_cnt = 0, err_cnt = 0;

    typedef struct packed {logic [2:0] adr; logic [7:0] dat;} wr_t;
    wr_t act_q[$];
    wr_t exp_q[$];

    assign wb_inta_i = if_m && ien_m;

    i2c_tx_sequencer #(
        .PRESCALE   (16'h008F),
        .FIFO_DEPTH (8),
        .WB_TIMEOUT (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_first   (s_first),
        .s_last    (s_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (rd_m),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_ack_i  (ack_m),
        .wb_inta_i (wb_inta_i)
    );

    // Core model: acks after lat cycles, logs writes, byte takes 20 cycles of TIP
    always @(posedge clk) begin
        if (timer > 0) begin
            timer <= timer - 1;
            if (timer == 1) if_m <= 1'b1;
        end
        if (wb_stb_o && wb_cyc_o) stb_run <= stb_run + 1;
        else begin
            if (stb_run != 0) last_run <= stb_run;
            stb_run <= 0;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
        if (ack_m) ack_m <= 1'b0;
        else if (wb_stb_o && wb_cyc_o && !stub) begin
            if (lat_cnt >= lat) begin
                ack_m   <= 1'b1;
                lat_cnt <= 0;
                if (wb_we_o) begin
                    act_q.push_back({wb_adr_o, wb_dat_o});
                    if (wb_adr_o == 3'd2) ien_m <= wb_dat_o[6];
                    if (wb_adr_o == 3'd4) begin
                        if (wb_dat_o[0]) if_m <= 1'b0;
                        if (wb_dat_o[4]) begin
                            timer    <= 20;
                            rxack_m  <= (byte_idx == nack_abs);
                            al_m     <= (byte_idx == al_abs);
                            byte_idx <= byte_idx + 1;
                        end
                    end
                end else begin
                    rd_m <= {rxack_m, 1'b0, al_m, 3'b000, (timer != 0), if_m};
                    if (timer != 0) tip_reads <= tip_reads + 1;
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    typedef struct {
        int         n;
        logic [7:0] b [4];
        int         nack;
        int         al;
        int         lat;
        logic       exp_done;
        logic [1:0] exp_code;
    } tc_t;
    tc_t tcs [6];

    int   n_tests = 0, n_fail = 0;
    logic stall_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Expected register writes for one byte; returns 1 if the packet ends here
    task automatic exp_byte(input logic [7:0] d, input logic f, input logic l,
                            input logic nk, input logic a, output logic stop);
        exp_wr(3'd3, d);
        exp_wr(3'd4, 8'h10 | (f ? 8'h80 : 8'h00) | (l ? 8'h40 : 8'h00));
`ifdef I2C_INT_WAIT_EN
        exp_wr(3'd4, 8'h01 | ((nk && !a) ? 8'h40 : 8'h00));
`else
        if (nk && !a) exp_wr(3'd4, 8'h40);
`endif
        stop = nk || a;
    endtask

    task automatic compare_writes(input string name);
        wr_t e, a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_q.size() == 0) begin
                chk({name, "_missing_write"}, 32'hFFFF_FFFF, {21'd0, e});
            end else begin
                a = act_q.pop_front();
                chk({name, "_write"}, {21'd0, a}, {21'd0, e});
            end
        end
        chk({name, "_extra_writes"}, act_q.size(), 0);
        act_q.delete();
    endtask

    task automatic push(input logic f, input logic l, input logic [7:0] d);
        s_valid = 1'b1;
        s_first = f;
        s_last  = l;
        s_data  = d;
        for (int k = 0; k < 3000; k++) begin
            if (s_ready) begin
                @(posedge clk);
                @(negedge clk);
                s_valid = 1'b0;
                return;
            end
            stall_seen = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("push_ready_bound", 0, 1);
    endtask

    // Wait for done/err beyond the snapshot plus busy low
    task automatic wait_end(input string name, input int d0, input int e0);
        for (int k = 0; k < 20000; k++) begin
            if ((done_cnt != d0 || err_cnt != e0) && !busy) begin
                repeat (4) @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk({name, "_end_bound"}, 0, 1);
    endtask

    task automatic run_case(input int i);
        int   d0, e0;
        logic stop;
        string nm;
        nm       = $sformatf("case%0d", i);
        lat      = tcs[i].lat;
        nack_abs = (tcs[i].nack < 0) ? -1 : byte_idx + tcs[i].nack;
        al_abs   = (tcs[i].al   < 0) ? -1 : byte_idx + tcs[i].al;
        d0       = done_cnt;
        e0       = err_cnt;
        stop     = 1'b0;
        for (int k = 0; k < tcs[i].n; k++) begin
            if (!stop) exp_byte(tcs[i].b[k], k == 0, k == tcs[i].n - 1,
                                k == tcs[i].nack, k == tcs[i].al, stop);
        end
        for (int k = 0; k < tcs[i].n; k++) push(k == 0, k == tcs[i].n - 1, tcs[i].b[k]);
        wait_end(nm, d0, e0);
        chk({nm, "_done_pulses"}, done_cnt - d0, tcs[i].exp_done ? 1 : 0);
        chk({nm, "_err_pulses"}, err_cnt - e0, tcs[i].exp_done ? 0 : 1);
        chk({nm, "_err_code"}, err_code, tcs[i].exp_code);
        compare_writes(nm);
    endtask

    task automatic expect_init();
        exp_wr(3'd0, 8'h8F);
        exp_wr(3'd1, 8'h00);
        exp_wr(3'd2, CtrExp);
    endtask

    task automatic wait_writes(input string name, input int n);
        for (int k = 0; k < 5000; k++) begin
            if (act_q.size() >= n) begin
                repeat (6) @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk({name, "_write_bound"}, 0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stop;
        int   e0;
        tcs[0] = '{n: 3, b: '{8'h10, 8'h4F, 8'h0A, 8'h00}, nack: -1, al: -1, lat: 1,
                   exp_done: 1'b1, exp_code: 2'b00};
        tcs[1] = '{n: 3, b: '{8'h10, 8'h4F, 8'h0A, 8'h00}, nack: 1, al: -1, lat: 1,
                   exp_done: 1'b0, exp_code: 2'b01};
        tcs[2] = '{n: 1, b: '{8'h10, 8'h00, 8'h00, 8'h00}, nack: -1, al: -1, lat: 2,
                   exp_done: 1'b1, exp_code: 2'b00};
        tcs[3] = '{n: 2, b: '{8'h10, 8'h55, 8'h00, 8'h00}, nack: 0, al: -1, lat: 1,
                   exp_done: 1'b0, exp_code: 2'b01};
        tcs[4] = '{n: 2, b: '{8'h10, 8'h66, 8'h00, 8'h00}, nack: -1, al: 0, lat: 1,
                   exp_done: 1'b0, exp_code: 2'b10};
        tcs[5] = '{n: 4, b: '{8'h10, 8'h01, 8'h02, 8'h03}, nack: -1, al: -1, lat: 3,
                   exp_done: 1'b1, exp_code: 2'b00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_stb_cyc", {wb_stb_o, wb_cyc_o, wb_we_o}, 0);
        chk("rst_adr_dat", {wb_adr_o, wb_dat_o}, 0);

        // Prescaler/control init, s_ready only after third ack
        expect_init();
        rst_n = 1'b1;
        for (int k = 0; k < 2000 && !s_ready; k++) @(negedge clk);
        chk("init_s_ready", s_ready, 1);
        chk("init_writes_at_ready", act_q.size(), 3);
        compare_writes("init");

        for (int i = 0; i < 6; i++) run_case(i);
`ifdef I2C_INT_WAIT_EN
        chk("no_sr_poll_before_inta", tip_reads, 0);
`else
        chk("tip_polled", tip_reads > 0, 1);
`endif

        // Backpressure: 10 bytes into an 8-deep FIFO on a slow bus
        lat = 6;
        nack_abs = -1;
        al_abs = -1;
        stall_seen = 1'b0;
        e0 = done_cnt;
        for (int k = 0; k < 10; k++) begin
            exp_byte((k == 0) ? 8'h10 : 8'hA0 + 8'(k), k == 0, k == 9, 1'b0, 1'b0, stop);
        end
        for (int k = 0; k < 10; k++) push(k == 0, k == 9, (k == 0) ? 8'h10 : 8'hA0 + 8'(k));
        chk("bp_s_ready_dropped", stall_seen, 1);
        wait_end("bp", e0, err_cnt);
        chk("bp_done_pulses", done_cnt - e0, 1);
        compare_writes("bp");

        // Wishbone timeout: no ack for 255 cycles, then core re-init
        lat = 1;
        stub = 1'b1;
        e0 = err_cnt;
        push(1'b1, 1'b1, 8'h10);
        for (int k = 0; k < 2000 && err_cnt == e0; k++) @(negedge clk);
        stub = 1'b0;
        chk("to_err_pulse", err_cnt - e0, 1);
        chk("to_err_code", err_code, 2'b11);
        chk("to_stb_cycles", last_run, 255);
        expect_init();
        wait_writes("to_reinit", 3);
        compare_writes("to_reinit");
        chk("to_busy_after", busy, 0);

        // Reset while a transfer is pending; the queued second packet must vanish
        stub = 1'b1;
        push(1'b1, 1'b1, 8'h10);
        push(1'b1, 1'b1, 8'h30);
        for (int k = 0; k < 200 && !wb_stb_o; k++) @(negedge clk);
        chk("mid_stb_high", wb_stb_o, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_stb_cyc_drop", {wb_stb_o, wb_cyc_o}, 0);
        chk("mid_s_ready", s_ready, 0);
        chk("mid_busy", busy, 1);
        @(negedge clk);
        stub = 1'b0;
        act_q.delete();
        expect_init();
        rst_n = 1'b1;
        for (int k = 0; k < 2000 && !s_ready; k++) @(negedge clk);
        repeat (200) @(negedge clk);
        compare_writes("mid_reinit");
        chk("mid_busy_after", busy, 0);
        chk("mid_err_code", err_code, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
